// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption core, one cipher round per clock.
// Round keys are expanded on the fly, one per round. Ciphertext decrypts with the
// existing combinational decrypt block.
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      plaintext/key handshake (in_ready high only in IDLE)
//   in_text, in_key        128-bit plaintext and key, byte 0 at [127:120]
//   out_valid/out_ready    ciphertext handshake (out_valid high only in DONE)
//   out_data               128-bit ciphertext, zero when idle if ZERO_OUT=1
//   busy                   high while rounds are being computed
module aes_encrypt_iter #(
    parameter int unsigned NR       = 10,
    parameter bit          ZERO_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int unsigned RND_W = 4;

    // Only AES-128 is supported.
    if (NR != 10) begin : g_bad_nr
        $error("aes_encrypt_iter: NR must be 10");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

    fsm_e             fsm_q;
    logic [RND_W-1:0] round_q;
    logic [7:0]       rcon_q;
    logic [127:0]     state_q;
    logic [127:0]     rkey_q;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next round key: RotWord, SubWord, rcon into MSB byte, then chained word xors.
    logic [31:0]  rot_w, sub_w, kt;
    logic [31:0]  nk0, nk1, nk2, nk3;
    logic [127:0] next_key;

    assign rot_w = {rkey_q[23:0], rkey_q[31:24]};
    assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    assign kt    = sub_w ^ {rcon_q, 24'h000000};
    assign nk0   = rkey_q[127:96] ^ kt;
    assign nk1   = rkey_q[95:64]  ^ nk0;
    assign nk2   = rkey_q[63:32]  ^ nk1;
    assign nk3   = rkey_q[31:0]   ^ nk2;
    assign next_key = {nk0, nk1, nk2, nk3};

    // Round datapath; byte i sits at [127-8i -: 8], column c holds bytes 4c..4c+3.
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] round_out;
    logic         last_round;

    assign last_round = (round_q == RND_W'(NR));

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_q[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates left by r columns.
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
            // Row of {02 03 01 01}, rotated right by r.
            assign mc[4*c+r] = xtime(sr[4*c+r]) ^ xtime(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                             ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign round_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= IDLE;
            round_q   <= '0;
            rcon_q    <= 8'h01;
            state_q   <= '0;
            rkey_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q  <= in_text ^ in_key;
                        rkey_q   <= in_key;
                        round_q  <= RND_W'(1);
                        rcon_q   <= 8'h01;
                        fsm_q    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    state_q <= round_out;
                    rkey_q  <= next_key;
                    rcon_q  <= xtime(rcon_q);
                    round_q <= round_q + RND_W'(1);
                    if (last_round) begin
                        fsm_q     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= round_out;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        if (ZERO_OUT) begin
                            out_data <= '0;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known-answer table, multi-cycle corner
// sequences and random vectors against a byte-level AES model (S-box derived from
// GF(2^8) inversion and the affine map).
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    aes_encrypt_iter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_text  (in_text),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] sb_t  [256];
    logic [7:0] isb_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] v, inv, s;
            v = 8'(a);
            inv = 8'h01;
            if (v == 8'h00) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, v);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_t[a]  = s;
            isb_t[s] = v;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // State after 'rounds' rounds (10 gives the ciphertext).
    function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt,
                                               input int rounds);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        x = pt ^ round_key(key, 0);
        for (int r = 1; r <= rounds; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_t[x[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    if (r != 10)
                        s[4*c+q] = gmul(8'h02, t[4*c+q]) ^ gmul(8'h03, t[4*c+(q+1)%4])
                                 ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
                    else
                        s[4*c+q] = t[4*c+q];
            for (int i = 0; i < 16; i++) x[127-8*i -: 8] = s[i];
            x = x ^ round_key(key, r);
        end
        return x;
    endfunction

    // Standard inverse cipher, standing in for the decrypt block.
    function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        x = ct ^ round_key(key, 10);
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = isb_t[s[4*((c-q+4)%4)+q]];
            for (int i = 0; i < 16; i++) x[127-8*i -: 8] = t[i];
            x = x ^ round_key(key, r);
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++)
                        t[4*c+q] = gmul(8'h0e, s[4*c+q]) ^ gmul(8'h0b, s[4*c+(q+1)%4])
                                 ^ gmul(8'h0d, s[4*c+(q+2)%4]) ^ gmul(8'h09, s[4*c+(q+3)%4]);
                for (int i = 0; i < 16; i++) x[127-8*i -: 8] = t[i];
            end
        end
        return x;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present one pair for the accept edge, then scramble inputs.
    task automatic send_block(input logic [127:0] key, input logic [127:0] text);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_key   = key;
        in_text  = text;
        tick();
        in_valid = 1'b0;
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_text  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] text;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_R1  = 128'h89d810e8855ace682d1843d8cb128fe4;

    initial begin
        vec_t vt [3];
        int   lat;
        int   acc_t [3];
        int   out_t [3];
        int   k, j, cyc;
        logic [127:0] rk, rt, ct;

        vt[0] = '{C1_KEY, C1_PT, C1_CT, 0};
        vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, 5};
        vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2};

        build_sbox();

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_text = '0; in_key = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_data", out_data, 0);
        reset = 1'b0;
        tick();

        // Known-answer table, with and without backpressure.
        for (int i = 0; i < 3; i++) begin
            out_ready = (vt[i].hold == 0);
            send_block(vt[i].key, vt[i].text);
            check("busy_after_accept", busy, 1);
            check("in_ready_after_accept", in_ready, 0);
            wait_out(lat);
            check("latency", lat, 10);
            check("kat_data", out_data, vt[i].exp);
            if (vt[i].hold == 0) begin
                tick();
                check("valid_one_cycle", out_valid, 0);
            end else begin
                for (int h = 0; h < vt[i].hold; h++) begin
                    tick();
                    check("hold_data", out_data, vt[i].exp);
                    check("hold_valid", out_valid, 1);
                    check("hold_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
                tick();
                check("valid_drop", out_valid, 0);
            end
            out_ready = 1'b0;
            check("in_ready_rise", in_ready, 1);
            check("zero_out_idle", out_data, 0);
        end

        // Round-1 intermediate state and input isolation during BUSY.
        out_ready = 1'b1;
        send_block(C1_KEY, C1_PT);
        tick();
        check("round1_state", dut.state_q, C1_R1);
        in_valid = 1'b1;
        in_key   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        in_text  = 128'h0123456789abcdef0123456789abcdef;
        tick();
        check("iso_in_ready", in_ready, 0);
        check("iso_busy", busy, 1);
        in_valid = 1'b0;
        wait_out(lat);
        check("iso_latency", lat, 8);
        check("iso_data", out_data, C1_CT);
        repeat (3) tick();
        check("iso_no_second_accept", busy, 0);
        out_ready = 1'b0;

        // Reset in the middle of round processing.
        send_block(C1_KEY, C1_PT);
        repeat (4) tick();
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_data", out_data, 0);
        check("midreset_busy", busy, 0);
        tick();
        reset = 1'b0;
        repeat (12) begin
            tick();
            check("midreset_no_output", out_valid, 0);
        end
        out_ready = 1'b1;
        send_block(C1_KEY, C1_PT);
        wait_out(lat);
        check("post_reset_data", out_data, C1_CT);
        tick();
        out_ready = 1'b0;

        // Reset while a result is waiting in DONE.
        send_block(C1_KEY, C1_PT);
        wait_out(lat);
        check("done_data", out_data, C1_CT);
        #2 reset = 1'b1;
        #1;
        check("donereset_out_data", out_data, 0);
        check("donereset_out_valid", out_valid, 0);
        check("donereset_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back streaming with in_valid and out_ready held high.
        k = 0; j = 0; cyc = 0;
        for (int i = 0; i < 3; i++) begin acc_t[i] = 0; out_t[i] = 0; end
        in_valid = 1'b1; out_ready = 1'b1;
        while (j < 3 && cyc < 200) begin
            if (in_ready) begin
                if (k < 3) begin
                    in_key = vt[k].key; in_text = vt[k].text; acc_t[k] = cyc; k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("stream_data", out_data, vt[j].exp);
                out_t[j] = cyc;
                j++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_count", j, 3);
        for (int i = 0; i < 3; i++) check("stream_latency", out_t[i] - acc_t[i], 11);
        for (int i = 1; i < 3; i++) check("stream_spacing", acc_t[i] - acc_t[i-1], 12);
        tick();

        // Random vectors against the model, with loopback through the inverse cipher.
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rt = {$urandom, $urandom, $urandom, $urandom};
            send_block(rk, rt);
            wait_out(lat);
            ct = out_data;
            check("rand_latency", lat, 10);
            check("rand_cipher", ct, model_enc(rk, rt, 10));
            check("rand_loopback", model_dec(rk, ct), rt);
            tick();
        end
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
